// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the fetch queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Canonical NOP (addi x0, x0, 0) shown to decode when nothing is valid
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One buffered fetch: instruction word plus the PC it was fetched from
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Width of a counter that must hold values 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Power-of-two depth synchronous FIFO with synchronous clear.
//                Head word is visible on rdata_o while not empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  rd_ptr_q;
    logic [c_AW-1:0]  wr_ptr_q;
    logic [CW-1:0]    count_q;

    logic             w_do_pop;
    logic             w_do_push;

    // A pop frees a slot this cycle, so push into a full FIFO is allowed then
    assign w_do_pop  = pop_i && (count_q != '0);
    assign w_do_push = push_i && (!full_o || w_do_pop);

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : In-order instruction fetch with a small response queue that
//                feeds the decode register; handles stall, flush, redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int c_CW = cnt_width(DEPTH);

    logic [31:0]     pc_q,          pc_d;
    logic [31:0]     rsp_pc_q,      rsp_pc_d;
    logic [c_CW-1:0] outstanding_q, outstanding_d;
    logic [c_CW-1:0] drop_q,        drop_d;
    logic            valid_q,       valid_d;
    logic [31:0]     instr_q,       instr_d;
    logic [31:0]     pcd_q,         pcd_d;
    logic [31:0]     pcp4_q,        pcp4_d;

    logic [c_CW-1:0] w_fifo_count;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic [63:0]     w_fifo_rdata;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic [c_CW:0]   w_occupancy;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic [31:0]     w_redirect_pc;

    // Queued plus in-flight words may never exceed the queue size
    assign w_occupancy    = {1'b0, w_fifo_count} + {1'b0, outstanding_q};
    assign imem_req_valid = rst_n && !PCSrcE
                         && (w_occupancy < (c_CW+1)'(DEPTH))
                         && (outstanding_q < c_CW'(MAX_OUTSTANDING));
    assign imem_req_addr  = pc_q;

    assign w_issue       = imem_req_valid && imem_req_ready;
    assign w_drop        = imem_rsp_valid && (drop_q != '0);
    assign w_push        = imem_rsp_valid && (drop_q == '0);
    assign w_pop         = !StallD && !FlushD && !PCSrcE && !w_fifo_empty;
    assign w_redirect_pc = PCTargetE & ~32'd3;

    assign w_head       = fetch_entry_t'(w_fifo_rdata);
    assign w_push_entry = '{instr: imem_rsp_data, pc: rsp_pc_q};

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .clear_i (PCSrcE),
        .wdata_i (w_push_entry),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    // Next-state for fetch PC, response tracking and the decode register
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        pcd_d         = pcd_q;
        pcp4_d        = pcp4_q;

        case ({w_issue, imem_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + c_CW'(1);
            2'b01:   outstanding_d = outstanding_q - c_CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (PCSrcE) begin
            // Everything in flight now belongs to the wrong path
            pc_d     = w_redirect_pc;
            rsp_pc_d = w_redirect_pc;
            drop_d   = outstanding_d;
        end else begin
            if (w_issue) pc_d     = pc_q + 32'd4;
            if (w_push)  rsp_pc_d = rsp_pc_q + 32'd4;
            if (w_drop)  drop_d   = drop_q - c_CW'(1);
        end

        if (PCSrcE || FlushD) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (!StallD) begin
            if (!w_fifo_empty) begin
                valid_d = 1'b1;
                instr_d = w_head.instr;
                pcd_d   = w_head.pc;
                pcp4_d  = w_head.pc + 32'd4;
            end else begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            valid_q       <= 1'b0;
            instr_q       <= NOP_INSTR;
            pcd_q         <= RESET_PC;
            pcp4_q        <= RESET_PC + 32'd4;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            pcd_q         <= pcd_d;
            pcp4_q        <= pcp4_d;
        end
    end

    // The occupancy limit must make an overflowing push impossible
    always_ff @(posedge clk) begin
        if (rst_n && !PCSrcE) begin
            assert (!(w_push && w_fifo_full && !w_pop))
                else $error("fetch_queue: push into full queue");
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed self-checking bench for fetch_queue with an
//                in-order, fixed-latency instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int tests = 0;
    int fails = 0;

    fetch_queue #(
        .DEPTH           (4),
        .RESET_PC        (32'h0000_0000),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents as a function of address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Memory model: requests accepted at edge k answer at edge k+lat
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    ecnt = 0;
    int    lat  = 1;

    always @(posedge clk) ecnt <= ecnt + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            if (imem_req_valid && imem_req_ready)
                mq.push_back('{addr: imem_req_addr, due: ecnt + 1 + lat});
            if (mq.size() > 0 && mq[0].due == ecnt + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memf(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (ValidD !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(tag, {31'd0, ValidD}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        StallD         = 1'b0;
        FlushD         = 1'b0;
        PCSrcE         = 1'b0;
        PCTargetE      = 32'h0;

        // ---------------- reset values, 1-cycle memory
        lat = 1;
        repeat (3) step();
        chk("rst_validd",  {31'd0, ValidD}, 32'd0);
        chk("rst_instrd",  InstrD, 32'h0000_0013);
        chk("rst_pcd",     PCD, 32'h0000_0000);
        chk("rst_pcp4d",   PCPlus4D, 32'h0000_0004);
        chk("rst_reqv",    {31'd0, imem_req_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("first_reqv",  {31'd0, imem_req_valid}, 32'd1);
        chk("first_addr",  imem_req_addr, 32'h0);
        step();
        step();
        chk("lat_validd0", {31'd0, ValidD}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("seq_validd", {31'd0, ValidD}, 32'd1);
            chk("seq_pcd",    PCD, 32'(4 * i));
            chk("seq_pcp4d",  PCPlus4D, 32'(4 * i + 4));
            chk("seq_instrd", InstrD, memf(32'(4 * i)));
        end

        // ---------------- stall 6 cycles
        StallD = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stall_pcd",    PCD, 32'h8);
            chk("stall_instrd", InstrD, memf(32'h8));
        end
        chk("stall_count", {28'd0, dut.u_fifo.count_o}, 32'd4);
        chk("stall_reqv",  {31'd0, imem_req_valid}, 32'd0);
        StallD = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("resume_validd", {31'd0, ValidD}, 32'd1);
            chk("resume_pcd",    PCD, 32'(32'hC + 4 * i));
        end

        // ---------------- 3-cycle memory, redirect with 3 reads in flight
        lat = 3;
        do_reset();
        step();
        step();
        step();
        chk("redir_outst", {28'd0, dut.outstanding_q}, 32'd3);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0102;
        step();
        PCSrcE = 1'b0;
        chk("redir_validd", {31'd0, ValidD}, 32'd0);
        chk("redir_instrd", InstrD, 32'h0000_0013);
        chk("redir_count",  {28'd0, dut.u_fifo.count_o}, 32'd0);
        chk("redir_addr",   imem_req_addr, 32'h0000_0100);
        wait_valid("redir_wait");
        chk("redir_pcd",    PCD, 32'h0000_0100);
        chk("redir_instr",  InstrD, memf(32'h0000_0100));

        // ---------------- flush with 0x10 at queue head
        lat = 1;
        do_reset();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_000C;
        step();
        PCSrcE = 1'b0;
        step();
        step();
        step();
        chk("pre_flush_pcd", PCD, 32'h0000_000C);
        FlushD = 1'b1;
        step();
        FlushD = 1'b0;
        chk("flush_validd", {31'd0, ValidD}, 32'd0);
        chk("flush_instrd", InstrD, 32'h0000_0013);
        chk("flush_count",  {28'd0, dut.u_fifo.count_o}, 32'd2);
        step();
        chk("post_flush_v",   {31'd0, ValidD}, 32'd1);
        chk("post_flush_pcd", PCD, 32'h0000_0010);

        // ---------------- memory not ready for 5 cycles
        imem_req_ready = 1'b0;
        #1;
        chk("nrdy_addr0", imem_req_addr, 32'h0000_0020);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("nrdy_addr", imem_req_addr, 32'h0000_0020);
            chk("nrdy_reqv", {31'd0, imem_req_valid}, 32'd1);
        end
        chk("nrdy_validd", {31'd0, ValidD}, 32'd0);
        chk("nrdy_outst",  {28'd0, dut.outstanding_q}, 32'd0);
        imem_req_ready = 1'b1;
        wait_valid("nrdy_wait");
        chk("nrdy_pcd", PCD, 32'h0000_0020);

        // ---------------- address wrap-around
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFF8;
        step();
        PCSrcE = 1'b0;
        wait_valid("wrap_wait");
        chk("wrap_pcd0",   PCD, 32'hFFFF_FFF8);
        chk("wrap_pcp4d0", PCPlus4D, 32'hFFFF_FFFC);
        step();
        chk("wrap_pcd1",   PCD, 32'hFFFF_FFFC);
        chk("wrap_pcp4d1", PCPlus4D, 32'h0000_0000);
        step();
        chk("wrap_pcd2",   PCD, 32'h0000_0000);
        chk("wrap_instr2", InstrD, memf(32'h0));

        // ---------------- reset mid-stream
        step();
        rst_n = 1'b0;
        step();
        chk("mrst_validd", {31'd0, ValidD}, 32'd0);
        chk("mrst_instrd", InstrD, 32'h0000_0013);
        chk("mrst_count",  {28'd0, dut.u_fifo.count_o}, 32'd0);
        chk("mrst_reqv",   {31'd0, imem_req_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mrst_addr", imem_req_addr, 32'h0000_0000);
        chk("mrst_reqv1", {31'd0, imem_req_valid}, 32'd1);
        wait_valid("mrst_wait");
        chk("mrst_pcd", PCD, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Fetch-side producer for the decode stage. Issues in-order instruction-memory reads and buffers the returned words with their PCs in a small queue.
- Presents one instruction per cycle to the decode register (InstrD/PCD/PCPlus4D/ValidD), whose op/funct3/funct7 fields drive the control unit.
- Handles decode stalls, decode flushes and PC redirects from Execute (taken branch, JAL/JALR).

Parameters:
- DEPTH, 4, queue entries (power of two, 2..16).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered memory reads (1..DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  read data valid; responses return in request order, latency ≥1 cycle.
- imem_rsp_data  in  32  instruction word.
- StallD  in  1  hold the decode register.
- FlushD  in  1  invalidate the decode register.
- PCSrcE  in  1  redirect fetch to PCTargetE.
- PCTargetE  in  32  redirect target; bits [1:0] ignored and forced to 0.
- InstrD  out  32  instruction to decode.
- PCD  out  32  PC of InstrD.
- PCPlus4D  out  32  PCD+4, mod 2^32.
- ValidD  out  1  decode register holds a real instruction.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low, on clk and rst_n.
- Reset values (rst_n sampled low at a rising edge):
  - ValidD=0, InstrD=32'h0000_0013 (NOP), PCD=RESET_PC, PCPlus4D=RESET_PC+4.
  - Queue empty; outstanding=0; drop=0.
  - Fetch PC=RESET_PC; imem_req_valid=0 during reset.
  - Reset mid-operation discards all state. Responses arriving after reset to pre-reset requests are not tracked; the memory must be reset together with this block.
- Issue:
  - imem_req_valid = !PCSrcE && (count + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
  - On valid&&ready: PC<=PC+4 (wraps 32'hFFFF_FFFC→0) and outstanding increments.
  - The address is held stable while valid && !ready.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop>0: data discarded, drop decrements.
  - Otherwise {data, pc} is pushed. The pushed pc comes from a response-PC counter that advances +4 per accepted response.
  - The occupancy rule guarantees the queue never overflows. A push to a full queue is an assertion failure.
- Decode register load: when !StallD && !FlushD && !PCSrcE:
  - If the queue is non-empty: pop the head into InstrD/PCD/PCPlus4D and set ValidD=1.
  - If the queue is empty: ValidD=0 and InstrD=NOP.
  - Minimum latency from request acceptance with 1-cycle memory: response at edge k+1 (pushed), ValidD at edge k+2.
- StallD=1: decode register and queue head held. The queue may still fill and requests may still issue within the occupancy limit.
- FlushD=1 (PCSrcE=0): ValidD<=0 and InstrD<=NOP. No pop; the queue is kept. FlushD has priority over StallD.
- Redirect, PCSrcE=1 (highest priority):
  - Queue cleared, ValidD<=0, InstrD<=NOP.
  - PC and response-PC <= PCTargetE&~3.
  - drop <= outstanding (counted after this cycle's request and response).
  - No request is issued in the redirect cycle. Fetch resumes the next cycle.
- Simultaneous push and pop: both take effect and count is unchanged. A pop while full and a push in the same cycle is legal.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR=32'h0000_0013.
  - typedef fetch_entry_t struct packed {logic [31:0] instr; logic [31:0] pc;}.
  - Counter width function clog2(DEPTH+1).
- Sub-module sync_fifo:
  - Parameters WIDTH=64, DEPTH.
  - Ports: push/pop/clear, full/empty/count.
  - Same clock and synchronous active-low reset.

Test Plan:
- Reset with 1-cycle memory, no stall. Expect:
  - First req addr 0x0 one cycle after rst_n rises.
  - ValidD=1 with PCD 0x0, 0x4, 0x8 on consecutive cycles.
  - PCPlus4D=PCD+4.
- StallD high 6 cycles with 1-cycle memory. Expect:
  - InstrD/PCD frozen.
  - Exactly DEPTH=4 entries buffered, then imem_req_valid=0.
  - After release, PCs continue contiguous with no gap or duplicate.
- 3-cycle memory latency, PCSrcE pulsed with PCTargetE=0x100 while 3 reads are outstanding. Expect:
  - 3 stale responses dropped.
  - Next ValidD instruction has PCD=0x100.
- FlushD pulse with queue holding PCs 0x10, 0x14. Expect:
  - ValidD=0, InstrD=0x00000013 for one cycle.
  - Then PCD=0x10 (queue intact).
- imem_req_ready held low 5 cycles. Expect:
  - imem_req_addr stable and outstanding unchanged.
  - ValidD=0 once the queue drains.
- Wrap-around: RESET_PC=32'hFFFF_FFF8. Expect:
  - PCD sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - PCPlus4D of FFFF_FFFC = 0.
- Reset asserted mid-stream. Expect:
  - Next cycle ValidD=0, queue empty, req addr = RESET_PC.
